// File: rtl/fxp_iq_framer.sv
// Pairs interleaved real/imag fixed-point words into complex samples and frames them
// through a two-bank ping-pong buffer, draining each full frame over valid/ready.
module fxp_iq_framer #(
  parameter int DATA_W    = 31,
  parameter int FRAME_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic              overflow
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {PH_REAL, PH_IMAG} phase_t;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

  logic [DATA_W-1:0] mem_re [2*FRAME_LEN];
  logic [DATA_W-1:0] mem_im [2*FRAME_LEN];

  logic [1:0]        full;
  logic [1:0]        full_set;
  logic [1:0]        full_clr;

  phase_t            phase;
  phase_t            phase_eff;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  wr_idx_eff;
  logic              wr_bank;
  logic [DATA_W-1:0] re_hold;
  logic              wr_drop;
  logic              wr_en;

  rd_state_t         rd_state;
  logic              rd_bank;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  rd_idx_nxt;
  logic              rd_done;

  // sync takes effect before the word arriving in the same cycle is classified
  always_comb begin
    phase_eff  = sync ? PH_REAL : phase;
    wr_idx_eff = sync ? '0 : wr_idx;
    wr_drop    = in_valid && full[wr_bank];
    wr_en      = in_valid && !full[wr_bank] && (phase_eff == PH_IMAG);
    full_set   = '0;
    if (wr_en && (wr_idx_eff == LAST_IDX))
      full_set[wr_bank] = 1'b1;
  end

  always_comb begin
    rd_idx_nxt = rd_idx + IDX_W'(1);
    rd_done    = (rd_state == R_DRAIN) && out_ready && (rd_idx == LAST_IDX);
    full_clr   = '0;
    if (rd_done)
      full_clr[rd_bank] = 1'b1;
  end

  // A set and a clear never target the same bank: writes need full=0, clears need full=1.
  always_ff @(posedge clk) begin
    if (reset)
      full <= '0;
    else
      full <= (full | full_set) & ~full_clr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= PH_REAL;
      wr_idx   <= '0;
      wr_bank  <= 1'b0;
      re_hold  <= '0;
      overflow <= 1'b0;
    end else begin
      phase  <= phase_eff;
      wr_idx <= wr_idx_eff;
      if (in_valid) begin
        // Dropped words still toggle the phase so real/imag alignment survives an overrun.
        phase <= (phase_eff == PH_REAL) ? PH_IMAG : PH_REAL;
        if (wr_drop) begin
          overflow <= 1'b1;
        end else if (phase_eff == PH_REAL) begin
          re_hold <= in_data;
        end else if (wr_idx_eff == LAST_IDX) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx_eff + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_re[{wr_bank, wr_idx_eff}] <= re_hold;
      mem_im[{wr_bank, wr_idx_eff}] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state  <= R_IDLE;
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (full[rd_bank]) begin
            rd_state  <= R_DRAIN;
            rd_idx    <= '0;
            out_valid <= 1'b1;
            out_first <= 1'b1;
            out_last  <= 1'b0;
            out_re    <= mem_re[{rd_bank, {IDX_W{1'b0}}}];
            out_im    <= mem_im[{rd_bank, {IDX_W{1'b0}}}];
          end
        end
        R_DRAIN: begin
          if (out_ready) begin
            if (rd_idx == LAST_IDX) begin
              // Returning through R_IDLE yields the single bubble between frames.
              rd_state  <= R_IDLE;
              rd_bank   <= ~rd_bank;
              rd_idx    <= '0;
              out_valid <= 1'b0;
              out_first <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              rd_idx    <= rd_idx_nxt;
              out_first <= 1'b0;
              out_last  <= (rd_idx_nxt == LAST_IDX);
              out_re    <= mem_re[{rd_bank, rd_idx_nxt}];
              out_im    <= mem_im[{rd_bank, rd_idx_nxt}];
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_iq_framer.sv
// Scoreboard bench for fxp_iq_framer with FRAME_LEN=4: expected samples are queued as
// words are fed and compared against the head of the queue whenever out_valid is high.
module tb_fxp_iq_framer;

  localparam int DW = 31;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          sync;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;
  logic          overflow;

  always #5 clk = ~clk;

  fxp_iq_framer #(.DATA_W(DW), .FRAME_LEN(FL)) dut (
    .clk      (clk),
    .reset    (reset),
    .sync     (sync),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_first(out_first),
    .out_last (out_last),
    .overflow (overflow)
  );

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          first;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_xfer = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int re, input int im, input int idx);
    exp_t e;
    e.re    = DW'(re);
    e.im    = DW'(im);
    e.first = (idx == 0);
    e.last  = (idx == FL - 1);
    sb.push_back(e);
  endtask

  task automatic feed(input int w);
    in_data  = DW'(w);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int c = 0; c < 200 && sb.size() != 0; c++) @(posedge clk);
    #1;
    check(tag, sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Output monitor: every valid cycle must present the scoreboard head (covers holds while stalled).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (sb.size() == 0) begin
          check("sb_empty", sb.size(), 1);
        end else begin
          e = sb[0];
          check("out_re",    out_re,    e.re);
          check("out_im",    out_im,    e.im);
          check("out_first", out_first, e.first);
          check("out_last",  out_last,  e.last);
          if (out_ready) begin
            void'(sb.pop_front());
            n_xfer++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            x0;
    logic [9:0]    pat;

    reset = 1'b1; sync = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_first", out_first, 0);
    check("rst_last",  out_last,  0);
    check("rst_re",    out_re,    0);
    check("rst_im",    out_im,    0);
    check("rst_ovf",   overflow,  0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: back-to-back frame, latency and burst shape
    out_ready = 1'b1;
    x0 = n_xfer;
    for (int k = 1; k <= 4; k++) begin
      push(k, -k, k - 1);
      feed(k);
      feed(-k);
    end
    check("t1_lat_n1", out_valid, 0);
    @(posedge clk);
    #1;
    check("t1_lat_n2", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_burst", out_valid, 1);
    end
    @(negedge clk);
    check("t1_after", out_valid, 0);
    check("t1_xfer", n_xfer - x0, 4);
    check("t1_ovf", overflow, 0);

    // 2: ready toggling 1,0,0,1 while the frame arrives and drains
    x0 = n_xfer;
    fork
      begin
        for (int k = 1; k <= 4; k++) begin
          push(10 * k, -10 * k, k - 1);
          feed(10 * k);
          feed(-10 * k);
        end
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = ((c % 4) == 0) || ((c % 4) == 3);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_empty("t2_drain");
    check("t2_xfer", n_xfer - x0, 4);

    // 3: three frames with no consumer; third is dropped
    out_ready = 1'b0;
    x0 = n_xfer;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        if (f < 2) push(100 * (f + 1) + k, 100 * (f + 1) + k + 50, k);
        feed(100 * (f + 1) + k);
        feed(100 * (f + 1) + k + 50);
      end
    end
    check("t3_ovf", overflow, 1);
    check("t3_noxfer", n_xfer - x0, 0);
    out_ready = 1'b1;
    pat = 10'b1111011110;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_bubble", out_valid, pat[9 - i]);
    end
    wait_empty("t3_drain");
    check("t3_xfer", n_xfer - x0, 8);
    check("t3_idle", out_valid, 0);

    // 4: sync discards a partial frame
    x0 = n_xfer;
    feed(10); feed(20); feed(30);
    sync = 1'b1;
    @(posedge clk);
    #1;
    sync = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(5 + 2 * k, 6 + 2 * k, k);
      feed(5 + 2 * k);
      feed(6 + 2 * k);
    end
    wait_empty("t4_drain");
    check("t4_xfer", n_xfer - x0, 4);

    // 4b: sync coincident with a valid word; that word becomes the real part at index 0
    x0 = n_xfer;
    feed(50);
    for (int k = 0; k < 4; k++) push(5 + 2 * k, 6 + 2 * k, k);
    sync = 1'b1;
    feed(5);
    sync = 1'b0;
    for (int w = 6; w <= 12; w++) feed(w);
    wait_empty("t4b_drain");
    check("t4b_xfer", n_xfer - x0, 4);

    // 5: reset mid-drain with the other bank full
    out_ready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        push(200 * (f + 1) + k, -(200 * (f + 1) + k), k);
        feed(200 * (f + 1) + k);
        feed(-(200 * (f + 1) + k));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    x0 = n_xfer;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("t5_partial", n_xfer - x0, 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_ovf", overflow, 0);
    reset = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    x0 = n_xfer;
    for (int k = 0; k < 4; k++) begin
      push(1000 + k, -1000 - k, k);
      feed(1000 + k);
      feed(-1000 - k);
    end
    wait_empty("t5_drain");
    check("t5_xfer", n_xfer - x0, 4);
    check("t5_ovf", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fxp_iq_framer.md
Name: fxp_iq_framer

Overview:
- Downstream consumer of the float-to-fixed converter output stream.
- Takes the converter's signed fixed-point words and their valid strobe, arriving as interleaved real/imaginary words, and pairs them into complex samples.
- Collects complex samples into frames of FRAME_LEN in a two-bank ping-pong buffer.
- Drains each completed frame to the FFT/equaliser stage over a valid/ready handshake with first/last markers; the input side has no backpressure, so overruns drop words and raise a sticky flag.

Parameters:
- DATA_W, 31, width of each real/imag word; matches converter output width (I_EXP+I_MNT).
- FRAME_LEN, 64, complex samples per frame; power of two, >=2.
- IDX_W, $clog2(FRAME_LEN), sample index width (derived, not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- sync  in  1  single-cycle resync pulse: realign pairing to real and restart the current partial frame.
- in_data  in  DATA_W  signed fixed-point word (converter int_out).
- in_valid  in  1  in_data valid (converter out_valid).
- out_re  out  DATA_W  real part of the current output sample.
- out_im  out  DATA_W  imaginary part of the current output sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample this cycle.
- out_first  out  1  current output sample is index 0 of its frame.
- out_last  out  1  current output sample is index FRAME_LEN-1 of its frame.
- overflow  out  1  sticky; at least one input word was dropped since reset.

Behaviour:
- Reset: all outputs 0. Internal state on reset:
  - both bank-full flags clear;
  - pairing phase = REAL;
  - write bank, write index, read bank and read index = 0;
  - read FSM = R_IDLE.
- Reset mid-operation discards partial and completed frames. A reset asserted while in_valid is high ignores that word.
- Pairing:
  - In phase REAL, a valid word is latched as the real part and phase toggles to IMAG.
  - In phase IMAG, a valid word completes the sample, which is written to wr_bank[wr_idx]; phase toggles back to REAL.
- Write index:
  - wr_idx increments per written sample.
  - Writing index FRAME_LEN-1 sets full[wr_bank], toggles wr_bank and wraps wr_idx to 0.
- Overrun: a valid word arriving while full[wr_bank]=1 is dropped and overflow is set.
  - Phase still toggles, so real/imag alignment survives.
  - wr_idx is not advanced.
- sync, when high:
  - phase = REAL and wr_idx = 0; any latched real part is discarded.
  - Full banks are untouched.
  - An in_valid word in the same cycle is treated as REAL at index 0 (sync applies first).
- Read FSM:
  - R_IDLE: if full[rd_bank], go to R_DRAIN next cycle with rd_idx=0.
  - R_DRAIN:
    - out_valid=1, out_re/out_im = rd_bank[rd_idx].
    - out_first=(rd_idx==0), out_last=(rd_idx==FRAME_LEN-1).
    - A transfer occurs when out_valid && out_ready; rd_idx increments on each transfer.
    - On transfer of the last sample: clear full[rd_bank], toggle rd_bank, return to R_IDLE.
- Output holds: while out_valid && !out_ready, out_re, out_im, out_first and out_last hold stable.
- Storage: either flops or RAM with registered read is acceptable, but output timing must be exactly as specified.
- Latency:
  - out_valid first rises 2 cycles after the cycle in which the frame's final imaginary word has in_valid=1.
  - If out_ready is held high, one sample per cycle transfers.
  - Exactly one bubble cycle (out_valid=0) separates consecutive frames, even if the other bank is already full.
- Simultaneous events:
  - The read side clearing full[b] takes effect the next cycle; a write to bank b in the same cycle is dropped (overflow set).
  - Setting full on one bank and clearing full on the other in the same cycle are both honoured.
- Arithmetic: no transformation; words are stored and emitted bit-exact (signed two's complement).

Test Plan:
1. FRAME_LEN=4, out_ready=1, feed words 1,-1,2,-2,3,-3,4,-4 consecutively.
   - out_valid rises 2 cycles after the -4 word.
   - Emits (1,-1),(2,-2),(3,-3),(4,-4) on four consecutive cycles, out_first on the first, out_last on the fourth; overflow=0.
2. Same frame with out_ready toggling 1,0,0,1,... -> each sample holds stable while stalled; order is unchanged; exactly 4 transfers.
3. out_ready=0, feed 3 full frames (24 words).
   - Frames 1 and 2 are buffered; all words of frame 3 are dropped and overflow=1.
   - After out_ready=1, exactly 8 samples (frames 1, 2) emerge, with a 1-cycle bubble between them.
4. Feed 3 words (10, 20, 30), pulse sync, then feed 8 words 5..12.
   - The frame emits (5,6),(7,8),(9,10),(11,12); the 10/20/30 words never appear.
5. Assert reset while a frame is draining (2 of 4 samples transferred) with the other bank full.
   - Next cycle: out_valid=0, overflow=0.
   - A subsequent fresh frame emits correctly from index 0 with out_first=1.
